mpsoc_apb_gpio: RTL and testbench
=================================

MPSOC_APB_GPIO -- requirements
Module: mpsoc_apb_gpio

Interface
REQ-001 SHALL have parameter PADDR_SIZE, default 4, APB address width.
REQ-002 SHALL have parameter PDATA_SIZE, default 8, APB data width and GPIO pin count.
REQ-003 SHALL have parameter SYNC_DEPTH, default 3, input synchronizer stages; values below 2 are treated as 2.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 PCLK  input  1  sole clock, rising edge.
REQ-006 PRESET  input  1  asynchronous active-high reset.
REQ-007 PSEL, PENABLE, PWRITE, PSTRB  input  1 each  APB responder controls.
REQ-008 PPROT  input  3  accepted and ignored.
REQ-009 PADDR  input  PADDR_SIZE  byte address.
REQ-010 PWDATA  input  PDATA_SIZE  write data.
REQ-011 PRDATA  output  PDATA_SIZE  read data.
REQ-012 PREADY  output  1  ready, constant 1 (zero wait states).
REQ-013 PSLVERR  output  1  error response.
REQ-014 gpio_i  input  PDATA_SIZE  asynchronous pin inputs.
REQ-015 gpio_o  output  PDATA_SIZE  pin output values.
REQ-016 gpio_oe  output  PDATA_SIZE  pin output enables.
REQ-017 irq_o  output  1  interrupt request.

Function
REQ-018 Register map SHALL be: 0 MODE (1 = open-drain), 1 DIRECTION (1 = output), 2 OUTPUT, 3 INPUT (read-only), 4 IRQ_EN, 5 IRQ_TYPE (1 = edge, 0 = level), 6 IRQ_POL (1 = rising/high, 0 = falling/low), 7 IRQ_STATUS (write-1-to-clear).
REQ-019 Setup phase (PSEL=1, PENABLE=0) SHALL register PRDATA from the addressed register, so PRDATA is valid throughout the access phase.
REQ-020 Write SHALL occur at the rising edge where PSEL, PENABLE, PWRITE and PSTRB are all 1; with PSTRB=0 the write SHALL be ignored but still complete.
REQ-021 Writes to INPUT SHALL be ignored without error.
REQ-022 Address decode SHALL use PADDR[2:0]; any nonzero PADDR[PADDR_SIZE-1:3] SHALL be unmapped.
REQ-023 Unmapped access SHALL give PSLVERR=1 in the access phase, PRDATA=0 and no state change.
REQ-024 PSLVERR SHALL be 0 whenever PSEL and PENABLE are not both 1.
REQ-025 gpio_o SHALL be OUTPUT & ~MODE; gpio_oe SHALL be DIRECTION & (~MODE | ~OUTPUT).
REQ-026 gpio_i SHALL pass through SYNC_DEPTH flops; INPUT is the last stage, and a pin change appears in INPUT SYNC_DEPTH edges later.
REQ-027 A delay flop after INPUT SHALL provide the previous value for edge detection.
REQ-028 IRQ_STATUS bit n SHALL be set at the edge after its condition is seen in INPUT, i.e. SYNC_DEPTH+1 edges after the pin change, when IRQ_EN[n]=1 and the condition holds:
- edge type: INPUT[n] changed to IRQ_POL[n];
- level type: INPUT[n]==IRQ_POL[n].
REQ-029 When a set condition and a W1C clear hit the same bit in the same cycle, set SHALL win; a level source still active SHALL re-set its bit on the next cycle.
REQ-030 IRQ_EN=0 SHALL block new sets but SHALL NOT clear bits already set.
REQ-031 irq_o SHALL be the OR-reduction of IRQ_STATUS, driven directly from the register with no added latency.

Reset
REQ-032 While PRESET=1, all registers, synchronizer and delay flops, PRDATA, PSLVERR, gpio_o, gpio_oe and irq_o SHALL be 0; PREADY SHALL be 1.
REQ-033 Reset asserted mid-transfer SHALL abort the transfer with no register write; the first access after deassertion SHALL behave normally.

Configuration
REQ-034 Macro MPSOC_APB_GPIO_IRQ_EN defined: addresses 4-7 and irq_o SHALL behave as specified in REQ-028 to REQ-031.
REQ-035 Macro MPSOC_APB_GPIO_IRQ_EN undefined: no interrupt logic; addresses 4-7 SHALL read 0, writes to them SHALL be ignored with PSLVERR=0, and irq_o SHALL be tied to 0.

Verification
REQ-036 Reset, then write DIRECTION=0xFF, OUTPUT=0xA5 -> gpio_o=0xA5, gpio_oe=0xFF; reads of 1 and 2 return 0xFF and 0xA5.
REQ-037 MODE=0xFF, DIRECTION=0xFF, OUTPUT=0x0F -> gpio_o=0x00, gpio_oe=0xF0.
REQ-038 gpio_i changed 0x00->0x3C -> INPUT reads 0x3C at edge 3 (SYNC_DEPTH=3) and not earlier.
REQ-039 IRQ_EN=0x01, IRQ_TYPE=0x01, IRQ_POL=0x01, gpio_i[0] rising -> IRQ_STATUS=0x01 and irq_o=1 at edge 4; write 0x01 to address 7 -> both return to 0.
REQ-040 Level-high IRQ on bit 1 with the pin held high; W1C issued in the same cycle as the set condition -> bit stays 1 and irq_o stays 1.
REQ-041 Read address 8 -> PSLVERR=1, PRDATA=0x00; write 0xFF to address 8 -> no register changes; write with PSTRB=0 to address 2 -> OUTPUT unchanged.

Source files
------------

// File: rtl/mpsoc_apb_gpio_if.sv
// APB responder bus bundle for mpsoc_apb_gpio.
// master drives the request side; slave returns data, ready and error.
interface mpsoc_apb_gpio_if #(
  parameter int PADDR_SIZE = 4,
  parameter int PDATA_SIZE = 8
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic                  PSTRB;
  logic [2:0]            PPROT;
  logic [PADDR_SIZE-1:0] PADDR;
  logic [PDATA_SIZE-1:0] PWDATA;
  logic [PDATA_SIZE-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PSTRB, PPROT, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PSTRB, PPROT, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/mpsoc_apb_gpio.sv
// APB GPIO block: mode/direction/output registers, synchronized inputs and
// optional per-pin interrupts.
// Optional feature: define MPSOC_APB_GPIO_IRQ_EN to build the interrupt
// registers (addresses 4-7) and irq_o; otherwise those addresses read 0,
// ignore writes without error, and irq_o is 0.

// One GPIO pin: input synchronizer plus (optionally) its interrupt status bit.
module mpsoc_apb_gpio_lane #(
  parameter int SYNC_DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  input  logic irq_en,
  input  logic irq_type,
  input  logic irq_pol,
  input  logic sts_clr,
  output logic pin_q,
  output logic sts
);
  localparam int SD = (SYNC_DEPTH < 2) ? 2 : SYNC_DEPTH;

  logic [SD-1:0] sync;

  // synchronizer chain; the last stage is the INPUT register bit
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= '0;
    else     sync <= {sync[SD-2:0], pin};

  assign pin_q = sync[SD-1];

`ifdef MPSOC_APB_GPIO_IRQ_EN
  logic pin_d;
  logic hit;

  // previous INPUT value, used to spot an edge
  always_ff @(posedge clk or posedge rst)
    if (rst) pin_d <= 1'b0;
    else     pin_d <= pin_q;

  // level: pin at polarity; edge: pin just moved to polarity
  assign hit = irq_en & (pin_q == irq_pol) & (~irq_type | (pin_q != pin_d));

  // sticky status; a same-cycle set beats the W1C clear
  always_ff @(posedge clk or posedge rst)
    if (rst) sts <= 1'b0;
    else     sts <= hit | (sts & ~sts_clr);
`else
  logic unused_irq;
  assign unused_irq = ^{irq_en, irq_type, irq_pol, sts_clr};
  assign sts = 1'b0;
`endif
endmodule

module mpsoc_apb_gpio #(
  parameter int PADDR_SIZE = 4,
  parameter int PDATA_SIZE = 8,
  parameter int SYNC_DEPTH = 3
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  mpsoc_apb_gpio_if.slave       apb,
  input  logic [PDATA_SIZE-1:0] gpio_i,
  output logic [PDATA_SIZE-1:0] gpio_o,
  output logic [PDATA_SIZE-1:0] gpio_oe,
  output logic                  irq_o
);
  localparam logic [2:0] A_MODE = 3'd0;
  localparam logic [2:0] A_DIR  = 3'd1;
  localparam logic [2:0] A_OUT  = 3'd2;
  localparam logic [2:0] A_IN   = 3'd3;
`ifdef MPSOC_APB_GPIO_IRQ_EN
  localparam logic [2:0] A_IEN  = 3'd4;
  localparam logic [2:0] A_ITYP = 3'd5;
  localparam logic [2:0] A_IPOL = 3'd6;
  localparam logic [2:0] A_ISTS = 3'd7;
`endif

  logic [PDATA_SIZE-1:0] mode_r, dir_r, out_r, in_q;
  logic [PDATA_SIZE-1:0] irq_en_r, irq_type_r, irq_pol_r, irq_sts, sts_clr;
  logic [PDATA_SIZE-1:0] rd_mux, prdata_r;
  logic [2:0]            addr;
  logic                  unmapped, setup, wr_en, err_r;
  logic                  unused_prot;

  assign unused_prot = ^apb.PPROT;

  assign addr     = apb.PADDR[2:0];
  assign unmapped = |(apb.PADDR >> 3);
  assign setup    = apb.PSEL & ~apb.PENABLE;
  assign wr_en    = apb.PSEL & apb.PENABLE & apb.PWRITE & apb.PSTRB & ~unmapped;

  // register read mux; unbuilt addresses read 0
  always_comb begin
    rd_mux = '0;
    case (addr)
      A_MODE: rd_mux = mode_r;
      A_DIR:  rd_mux = dir_r;
      A_OUT:  rd_mux = out_r;
      A_IN:   rd_mux = in_q;
`ifdef MPSOC_APB_GPIO_IRQ_EN
      A_IEN:  rd_mux = irq_en_r;
      A_ITYP: rd_mux = irq_type_r;
      A_IPOL: rd_mux = irq_pol_r;
      A_ISTS: rd_mux = irq_sts;
`endif
      default: rd_mux = '0;
    endcase
  end

  // pin control registers; INPUT is read-only and ignores writes
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      mode_r <= '0;
      dir_r  <= '0;
      out_r  <= '0;
    end else if (wr_en) begin
      case (addr)
        A_MODE:  mode_r <= apb.PWDATA;
        A_DIR:   dir_r  <= apb.PWDATA;
        A_OUT:   out_r  <= apb.PWDATA;
        default: ;
      endcase
    end

`ifdef MPSOC_APB_GPIO_IRQ_EN
  // interrupt configuration registers
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      irq_en_r   <= '0;
      irq_type_r <= '0;
      irq_pol_r  <= '0;
    end else if (wr_en) begin
      case (addr)
        A_IEN:   irq_en_r   <= apb.PWDATA;
        A_ITYP:  irq_type_r <= apb.PWDATA;
        A_IPOL:  irq_pol_r  <= apb.PWDATA;
        default: ;
      endcase
    end

  assign sts_clr = (wr_en && addr == A_ISTS) ? apb.PWDATA : '0;
`else
  assign irq_en_r   = '0;
  assign irq_type_r = '0;
  assign irq_pol_r  = '0;
  assign sts_clr    = '0;
`endif

  // capture read data and error in setup so both hold through the access phase
  always_ff @(posedge PCLK or posedge PRESET)
    if (PRESET) begin
      prdata_r <= '0;
      err_r    <= 1'b0;
    end else if (setup) begin
      prdata_r <= unmapped ? '0 : rd_mux;
      err_r    <= unmapped;
    end

  assign apb.PRDATA  = prdata_r;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = apb.PSEL & apb.PENABLE & err_r;

  for (genvar i = 0; i < PDATA_SIZE; i++) begin : g_lane
    mpsoc_apb_gpio_lane #(.SYNC_DEPTH(SYNC_DEPTH)) u_lane (
      .clk      (PCLK),
      .rst      (PRESET),
      .pin      (gpio_i[i]),
      .irq_en   (irq_en_r[i]),
      .irq_type (irq_type_r[i]),
      .irq_pol  (irq_pol_r[i]),
      .sts_clr  (sts_clr[i]),
      .pin_q    (in_q[i]),
      .sts      (irq_sts[i])
    );
  end

  // open-drain pins never drive 1: they release (oe=0) instead
  assign gpio_o  = out_r & ~mode_r;
  assign gpio_oe = dir_r & (~mode_r | ~out_r);
  assign irq_o   = |irq_sts;
endmodule

// File: tb/tb_mpsoc_apb_gpio.sv
// Bench for mpsoc_apb_gpio: APB transfers push their expected response to a
// scoreboard queue, which is popped and compared in the access phase.
module tb_mpsoc_apb_gpio;
  logic       PCLK = 1'b0;
  logic       PRESET;
  logic [7:0] gpio_i, gpio_o, gpio_oe;
  logic       irq_o;

  mpsoc_apb_gpio_if #(.PADDR_SIZE(4), .PDATA_SIZE(8)) apb ();

  mpsoc_apb_gpio #(.PADDR_SIZE(4), .PDATA_SIZE(8), .SYNC_DEPTH(3)) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .apb     (apb),
    .gpio_i  (gpio_i),
    .gpio_o  (gpio_o),
    .gpio_oe (gpio_oe),
    .irq_o   (irq_o)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    string      tag;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [3:0] addr, input logic [7:0] wdata,
                          input logic strb);
    exp_t e;
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr;
    apb.PADDR = addr; apb.PWDATA = wdata; apb.PSTRB = strb;
    @(negedge PCLK);
    chk("setup_err", apb.PSLVERR, 0);
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    @(negedge PCLK);
    chk("sb_size", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.tag, "_err"}, apb.PSLVERR, e.err);
      chk({e.tag, "_rdy"}, apb.PREADY, 1);
      if (!wr) chk(e.tag, apb.PRDATA, e.data);
    end
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [3:0] addr, input logic [7:0] data,
                    input logic err);
    exp_t e;
    e.tag = tag; e.data = data; e.err = err;
    exp_q.push_back(e);
    apb_xfer(1'b0, addr, 8'h00, 1'b1);
  endtask

  task automatic wr(input string tag, input logic [3:0] addr, input logic [7:0] data,
                    input logic strb, input logic err);
    exp_t e;
    e.tag = tag; e.data = 8'h00; e.err = err;
    exp_q.push_back(e);
    apb_xfer(1'b1, addr, data, strb);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESET = 1'b1;
    gpio_i = 8'h00;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b1; apb.PWRITE = 1'b0; apb.PSTRB = 1'b1;
    apb.PPROT = 3'b000; apb.PADDR = 4'h8; apb.PWDATA = 8'h00;

    // reset state, with an unmapped access phase held on the bus
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_prdata", apb.PRDATA, 0);
    chk("rst_slverr", apb.PSLVERR, 0);
    chk("rst_pready", apb.PREADY, 1);
    chk("rst_gpio_o", gpio_o, 0);
    chk("rst_gpio_oe", gpio_oe, 0);
    chk("rst_irq", irq_o, 0);
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;

    // push-pull outputs
    wr("w_dir", 4'h1, 8'hFF, 1'b1, 1'b0);
    wr("w_out", 4'h2, 8'hA5, 1'b1, 1'b0);
    @(negedge PCLK);
    chk("pp_gpio_o", gpio_o, 8'hA5);
    chk("pp_gpio_oe", gpio_oe, 8'hFF);
    rd("r_dir", 4'h1, 8'hFF, 1'b0);
    rd("r_out", 4'h2, 8'hA5, 1'b0);

    // open-drain outputs
    wr("w_mode", 4'h0, 8'hFF, 1'b1, 1'b0);
    wr("w_out2", 4'h2, 8'h0F, 1'b1, 1'b0);
    @(negedge PCLK);
    chk("od_gpio_o", gpio_o, 8'h00);
    chk("od_gpio_oe", gpio_oe, 8'hF0);
    rd("r_mode", 4'h0, 8'hFF, 1'b0);
    wr("w_mode0", 4'h0, 8'h00, 1'b1, 1'b0);
    @(negedge PCLK);
    chk("pp2_gpio_o", gpio_o, 8'h0F);
    chk("pp2_gpio_oe", gpio_oe, 8'hFF);

    // unmapped accesses, strobe-less write, write to INPUT
    rd("r_unmap8", 4'h8, 8'h00, 1'b1);
    wr("w_unmap8", 4'h8, 8'hFF, 1'b1, 1'b1);
    wr("w_unmapA", 4'hA, 8'hFF, 1'b1, 1'b1);
    rd("r_mode_k", 4'h0, 8'h00, 1'b0);
    rd("r_out_k", 4'h2, 8'h0F, 1'b0);
    wr("w_nostrb", 4'h2, 8'h77, 1'b0, 1'b0);
    rd("r_out_ns", 4'h2, 8'h0F, 1'b0);
    wr("w_input", 4'h3, 8'hFF, 1'b1, 1'b0);
    rd("r_input0", 4'h3, 8'h00, 1'b0);

    // synchronizer latency: INPUT changes at edge 3 after the pin change
    @(posedge PCLK); #1;
    gpio_i = 8'h3C;
    @(posedge PCLK);
    rd("in_edge3", 4'h3, 8'h00, 1'b0);
    gpio_i = 8'h00;
    repeat (6) @(posedge PCLK);
    @(posedge PCLK); #1;
    gpio_i = 8'h3C;
    repeat (2) @(posedge PCLK);
    rd("in_edge4", 4'h3, 8'h3C, 1'b0);
    gpio_i = 8'h00;
    repeat (6) @(posedge PCLK);

`ifdef MPSOC_APB_GPIO_IRQ_EN
    // rising-edge interrupt on bit 0
    wr("w_ityp", 4'h5, 8'h01, 1'b1, 1'b0);
    wr("w_ipol", 4'h6, 8'h01, 1'b1, 1'b0);
    wr("w_ien", 4'h4, 8'h01, 1'b1, 1'b0);
    repeat (3) @(posedge PCLK);
    @(posedge PCLK); #1;
    gpio_i = 8'h01;
    for (int k = 1; k <= 4; k++) begin
      @(posedge PCLK);
      @(negedge PCLK);
      chk($sformatf("irq_edge%0d", k), irq_o, (k >= 4) ? 1 : 0);
    end
    rd("r_sts_e", 4'h7, 8'h01, 1'b0);
    wr("w_w1c_e", 4'h7, 8'h01, 1'b1, 1'b0);
    @(negedge PCLK);
    chk("irq_clr_e", irq_o, 0);
    rd("r_sts_e0", 4'h7, 8'h00, 1'b0);

    // level-high interrupt on bit 1: set beats a same-cycle clear
    wr("w_ien0", 4'h4, 8'h00, 1'b1, 1'b0);
    wr("w_ityp0", 4'h5, 8'h00, 1'b1, 1'b0);
    wr("w_ipol2", 4'h6, 8'h02, 1'b1, 1'b0);
    gpio_i = 8'h02;
    repeat (5) @(posedge PCLK);
    wr("w_ien2", 4'h4, 8'h02, 1'b1, 1'b0);
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    chk("irq_lvl", irq_o, 1);
    wr("w_w1c_l", 4'h7, 8'h02, 1'b1, 1'b0);
    @(negedge PCLK);
    chk("irq_lvl_hold", irq_o, 1);
    rd("r_sts_l", 4'h7, 8'h02, 1'b0);
    // disabling does not clear an already-set bit
    wr("w_ien_off", 4'h4, 8'h00, 1'b1, 1'b0);
    rd("r_sts_off", 4'h7, 8'h02, 1'b0);
    @(negedge PCLK);
    chk("irq_off_hold", irq_o, 1);
    wr("w_w1c_l2", 4'h7, 8'h02, 1'b1, 1'b0);
    @(negedge PCLK);
    chk("irq_lvl_clr", irq_o, 0);
    rd("r_sts_l0", 4'h7, 8'h00, 1'b0);
    gpio_i = 8'h00;
`else
    // interrupt block absent: addresses 4-7 read 0, writes are harmless
    for (int a = 4; a < 8; a++) begin
      wr($sformatf("w_noirq%0d", a), a[3:0], 8'hFF, 1'b1, 1'b0);
      rd($sformatf("r_noirq%0d", a), a[3:0], 8'h00, 1'b0);
    end
    gpio_i = 8'hFF;
    repeat (6) @(posedge PCLK);
    @(negedge PCLK);
    chk("noirq_irq", irq_o, 0);
    gpio_i = 8'h00;
    repeat (6) @(posedge PCLK);
    @(negedge PCLK);
    chk("noirq_irq2", irq_o, 0);
`endif

    // reset during an access phase aborts the write
    rd("r_out_pre", 4'h2, 8'h0F, 1'b0);
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
    apb.PADDR = 4'h2; apb.PWDATA = 8'h5A; apb.PSTRB = 1'b1;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    #2 PRESET = 1'b1;
    @(negedge PCLK);
    chk("mid_rst_slverr", apb.PSLVERR, 0);
    chk("mid_rst_gpio_oe", gpio_oe, 0);
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    rd("r_out_abort", 4'h2, 8'h00, 1'b0);
    wr("w_out_post", 4'h2, 8'h3C, 1'b1, 1'b0);
    rd("r_out_post", 4'h2, 8'h3C, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
